// File: rtl/stage_memory.sv
// stage_memory: MEM pipeline stage with a registered data-memory request and a MEM/WB register; DMEM_MISALIGN_TRAP_EN turns misaligned accesses into faults
module stage_memory (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Valid,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic        i_RegWrite,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_AluResult,
  input  logic [31:0] i_rs2Value,
  input  logic [4:0]  i_rd,
  output logic        o_DMemReq,
  output logic        o_DMemWe,
  output logic [31:0] o_DMemAddr,
  output logic [31:0] o_DMemWData,
  output logic [3:0]  o_DMemByteEn,
  input  logic        i_DMemAck,
  input  logic [31:0] i_DMemRData,
  output logic        o_Stall,
  output logic        o_Valid,
  output logic        o_RegWrite,
  output logic [4:0]  o_rd,
  output logic [31:0] o_WritebackValue,
  output logic        o_Fault
);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic mem_op, store, is_byte, is_half, misaligned, trap;
  logic [1:0] off, off_q, f3_q;
  logic sign_q, rw_q, st_q;
  logic [4:0] rd_q;
  logic [31:0] st_data, ld_shift, ld_val;
  logic [3:0] st_be;
  // decode the access, build store lanes and extract load data; funct3 x11/110 fall through to word
  always_comb begin
    mem_op = i_Valid & (i_MemRead | i_MemWrite);
    store = i_MemWrite;
    is_byte = i_Funct3[1:0] == 2'b00;
    is_half = i_Funct3[1:0] == 2'b01;
    misaligned = is_half ? i_AluResult[0] : !is_byte && |i_AluResult[1:0];
    trap = TRAP && misaligned;
    off = is_byte ? i_AluResult[1:0] : is_half ? {i_AluResult[1], 1'b0} : 2'b00;
    st_data = is_byte ? {4{i_rs2Value[7:0]}} : is_half ? {2{i_rs2Value[15:0]}} : i_rs2Value;
    st_be = !store ? 4'b1111 : is_byte ? 4'b0001 << off : is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    o_Stall = state == IDLE ? mem_op & ~trap : ~i_DMemAck;
    ld_shift = i_DMemRData >> {off_q, 3'b000};
    ld_val = f3_q == 2'b00 ? {{24{sign_q & ld_shift[7]}}, ld_shift[7:0]} :
             f3_q == 2'b01 ? {{16{sign_q & ld_shift[15]}}, ld_shift[15:0]} : i_DMemRData;
  end
  // accept/issue/retire state machine with registered memory request and MEM/WB outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= IDLE;
      o_DMemReq <= 1'b0;
      o_DMemWe <= 1'b0;
      o_DMemAddr <= '0;
      o_DMemWData <= '0;
      o_DMemByteEn <= '0;
      o_Valid <= 1'b0;
      o_RegWrite <= 1'b0;
      o_rd <= '0;
      o_WritebackValue <= '0;
      o_Fault <= 1'b0;
      off_q <= '0;
      f3_q <= '0;
      sign_q <= 1'b0;
      rw_q <= 1'b0;
      st_q <= 1'b0;
      rd_q <= '0;
    end else if (state == IDLE) begin
      if (mem_op & ~trap) begin
        state <= BUSY;
        o_DMemReq <= 1'b1;
        o_DMemWe <= store;
        o_DMemAddr <= {i_AluResult[31:2], 2'b00};
        o_DMemWData <= st_data;
        o_DMemByteEn <= st_be;
        off_q <= off;
        f3_q <= is_byte ? 2'b00 : is_half ? 2'b01 : 2'b10;
        sign_q <= ~i_Funct3[2];
        rw_q <= i_RegWrite;
        st_q <= store;
        rd_q <= i_rd;
        o_Valid <= 1'b0;
        o_RegWrite <= 1'b0;
        o_Fault <= 1'b0;
      end else begin
        o_Valid <= i_Valid;
        o_RegWrite <= i_Valid & i_RegWrite & ~mem_op;
        o_Fault <= mem_op & trap;
        o_rd <= i_rd;
        o_WritebackValue <= i_AluResult;
      end
    end else if (i_DMemAck) begin
      state <= IDLE;
      o_DMemReq <= 1'b0;
      o_DMemWe <= 1'b0;
      o_Valid <= 1'b1;
      o_RegWrite <= rw_q & ~st_q;
      o_rd <= rd_q;
      o_WritebackValue <= ld_val;
      o_Fault <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      o_RegWrite <= 1'b0;
    end
  end
endmodule
